// File: rtl/usb_pkg.sv
// Shared USB line-level types: line states from the differential pair,
// the NRZI receiver FSM states and the default packet length limit.
package usb_pkg;

  localparam int USB_MAX_BITS = 1200;

  typedef enum logic [1:0] {
    J   = 2'd0,
    K   = 2'd1,
    SE0 = 2'd2,
    SE1 = 2'd3
  } line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EOP1 = 2'd2,
    EOP2 = 2'd3
  } state_t;

  function automatic line_t line_decode(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return J;
      2'b01:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/counter.sv
// Saturating up/down counter with clear and increment controls.
// When clear and increment coincide, the count restarts at one step from zero.
module counter #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up,
  input  logic         inc_cnt,
  input  logic         clr_cnt,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= (inc_cnt && up) ? W'(1) : '0;
    end else if (inc_cnt) begin
      if (up) begin
        if (cnt != MAX) cnt <= cnt + 1'b1;
      end else begin
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nrzi_rx.sv
// NRZI receive decoder and line-state tracker: frames packets from the first
// K after idle to EOP and flags SE1, malformed EOP and babble as line errors.
module nrzi_rx
  import usb_pkg::*;
#(
  parameter int MAX_BITS = USB_MAX_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp,
  input  logic       dm,
  output logic       outb,
  output logic       recving,
  output logic       eop,
  output logic       err,
  output logic [1:0] fsm_state,
  output logic       prev_k
);

  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BITS);

  state_t        state;
  line_t         prev;
  line_t         line;
  logic [CW-1:0] bitcnt;
  logic          start;
  logic          clr_cnt;
  logic          inc_cnt;

  assign line      = line_decode(dp, dm);
  assign fsm_state = state;
  assign prev_k    = (prev == K);

  // bitcnt includes the packet's first bit, so it equals the number of bits
  // already delivered; a J/K arriving when it is at MAX_BITS is babble.
  assign start   = (state == IDLE) && (line == K);
  assign clr_cnt = start;
  assign inc_cnt = start || ((state == RECV) && ((line == J) || (line == K)));

  counter #(
    .W   (CW),
    .MAX (MAX_CNT)
  ) u_bitcnt (
    .clk     (clk),
    .rst     (rst),
    .up      (1'b1),
    .inc_cnt (inc_cnt),
    .clr_cnt (clr_cnt),
    .cnt     (bitcnt)
  );

  // outb carries a decoded bit only while recving is high; otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prev    <= J;
      outb    <= 1'b1;
      recving <= 1'b0;
      eop     <= 1'b0;
      err     <= 1'b0;
    end else begin
      eop <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          case (line)
            K: begin
              state   <= RECV;
              prev    <= K;
              outb    <= 1'b0;
              recving <= 1'b1;
            end
            SE1:     err <= 1'b1;
            default: ;
          endcase
        end
        RECV: begin
          case (line)
            J, K: begin
              if (bitcnt == MAX_CNT) begin
                err     <= 1'b1;
                recving <= 1'b0;
                state   <= IDLE;
                prev    <= J;
              end else begin
                outb <= (line == prev);
                prev <= line;
              end
            end
            SE0: begin
              state   <= EOP1;
              recving <= 1'b0;
            end
            default: begin
              err     <= 1'b1;
              recving <= 1'b0;
              state   <= IDLE;
              prev    <= J;
            end
          endcase
        end
        EOP1: begin
          if (line == SE0) begin
            state <= EOP2;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
            prev  <= J;
          end
        end
        default: begin
          if (line != SE0) begin
            if (line == J) eop <= 1'b1;
            else           err <= 1'b1;
            state <= IDLE;
            prev  <= J;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nrzi_rx.sv
// Bench for nrzi_rx: packets are built from decoded bits, NRZI-encoded onto
// the line, and the expected per-cycle outputs come from the packet structure.
module tb_nrzi_rx;

  localparam int MAXB = 16;
  localparam logic [1:0] L_J = 2'b10, L_K = 2'b01, L_SE0 = 2'b00, L_SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dp  = 1'b1;
  logic       dm  = 1'b0;
  logic       outb, recving, eop, err, prev_k;
  logic [1:0] fsm_state;

  int errors = 0;
  int checks = 0;

  logic [1:0] line_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  logic       pkt_bits[$];
  logic       m_outb = 1'b1;

  always #5 clk = ~clk;

  nrzi_rx #(.MAX_BITS(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .dp        (dp),
    .dm        (dm),
    .outb      (outb),
    .recving   (recving),
    .eop       (eop),
    .err       (err),
    .fsm_state (fsm_state),
    .prev_k    (prev_k)
  );

  // expected word per sampled line state: {recving, outb, eop, err}
  task automatic push(input logic [1:0] l, input logic rec, input logic e, input logic r);
    line_q.push_back(l);
    exp_q.push_back({rec, m_outb, e, r});
  endtask

  // NRZI encode pkt_bits from idle J: a 0 toggles the line, a 1 keeps it.
  task automatic add_packet(output bit babbled);
    logic [1:0] level;
    level   = L_J;
    babbled = 1'b0;
    for (int i = 0; i < pkt_bits.size(); i++) begin
      if (pkt_bits[i] == 1'b0) level = (level == L_J) ? L_K : L_J;
      if (i < MAXB) begin
        m_outb = pkt_bits[i];
        push(level, 1'b1, 1'b0, 1'b0);
      end else begin
        push(level, 1'b0, 1'b0, 1'b1);
        babbled = 1'b1;
        break;
      end
    end
    pkt_bits.delete();
  endtask

  task automatic add_eop(input int kind);
    case (kind)
      0: begin push(L_SE0,0,0,0); push(L_SE0,0,0,0); push(L_J,0,1,0); end
      1: begin push(L_SE0,0,0,0); push(L_J,0,0,1); end
      2: begin push(L_SE0,0,0,0); push(L_SE0,0,0,0); push(L_SE0,0,0,0); push(L_J,0,1,0); end
      3: begin push(L_SE0,0,0,0); push(L_SE0,0,0,0); push(L_K,0,0,1); end
      default: begin push(L_SE0,0,0,0); push(L_SE1,0,0,1); end
    endcase
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(L_J, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_sync();
    for (int i = 0; i < 7; i++) pkt_bits.push_back(1'b0);
    pkt_bits.push_back(1'b1);
  endtask

  task automatic drive_all();
    logic [1:0] l;
    while (line_q.size() > 0) begin
      l = line_q.pop_front();
      {dp, dm} = l;
      @(posedge clk);
      #1;
      obs_q.push_back({recving, outb, eop, err});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {dp, dm} = L_J;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({outb, recving, eop, err, fsm_state, prev_k} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'(usb_pkg::IDLE), 1'b0}) begin
      errors++;
      $display("FAIL reset: got outb/rec/eop/err/state/prevk=%b%b%b%b/%0d/%b exp 1000/0/0",
               outb, recving, eop, err, fsm_state, prev_k);
    end
    rst = 1'b0;
    m_outb = 1'b1;
  endtask

  task automatic test_sync();
    bit b;
    add_idle(2);
    add_sync();
    add_packet(b);
    add_eop(0);
    drive_all();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sync cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_full_packet();
    bit b;
    logic [7:0] data;
    data = 8'b1011_0010;
    add_idle(1);
    add_sync();
    for (int i = 7; i >= 0; i--) pkt_bits.push_back(data[i]);
    add_packet(b);
    add_eop(0);
    add_idle(1);
    add_sync();
    add_packet(b);
    add_eop(2);
    drive_all();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_packet cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_short_eop();
    bit b;
    add_sync(); add_packet(b); add_eop(1);
    add_sync(); add_packet(b); add_eop(3);
    add_idle(1);
    add_sync(); add_packet(b); add_eop(4);
    add_idle(1);
    add_sync(); add_packet(b); add_eop(0);
    drive_all();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short_eop cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_se1();
    bit b;
    for (int i = 0; i < 5; i++) pkt_bits.push_back(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
    add_packet(b);
    push(L_SE1, 1'b0, 1'b0, 1'b1);
    add_idle(1);
    push(L_SE1, 1'b0, 1'b0, 1'b1);
    push(L_SE0, 1'b0, 1'b0, 1'b0);
    add_idle(1);
    drive_all();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL se1 cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_babble();
    bit b;
    int n_err;
    pkt_bits.push_back(1'b0);
    for (int i = 1; i < 20; i++) pkt_bits.push_back(1'($urandom_range(0, 1)));
    add_packet(b);
    add_idle(3);
    drive_all();
    n_err = 0;
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL babble cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
      n_err += int'(obs_q[i][0]);
    end
    checks++;
    if (n_err != 1) begin
      errors++;
      $display("FAIL babble err_count: got %0d exp 1", n_err);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bit b;
    for (int i = 0; i < 4; i++) pkt_bits.push_back(1'b0);
    add_packet(b);
    drive_all();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid pre cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    rst = 1'b1;
    {dp, dm} = L_SE0;
    @(posedge clk);
    #1;
    checks++;
    if ({outb, recving, eop, err, fsm_state, prev_k} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'(usb_pkg::IDLE), 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got outb/rec/eop/err/state/prevk=%b%b%b%b/%0d/%b exp 1000/0/0",
               outb, recving, eop, err, fsm_state, prev_k);
    end
    rst = 1'b0;
    m_outb = 1'b1;
    add_idle(1);
    add_sync();
    for (int i = 0; i < 6; i++) pkt_bits.push_back(1'($urandom_range(0, 1)));
    add_packet(b);
    add_eop(0);
    drive_all();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid post cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit b;
    int len;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 20);
      pkt_bits.push_back(1'b0);
      for (int i = 1; i < len; i++) pkt_bits.push_back(1'($urandom_range(0, 1)));
      add_packet(b);
      if (b) add_idle(2);
      else   add_eop($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) push(L_SE1, 1'b0, 1'b0, 1'b1);
      add_idle($urandom_range(0, 2));
    end
    drive_all();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got rec/outb/eop/err=%b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_sync();
    test_full_packet();
    test_short_eop();
    test_se1();
    test_babble();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
